// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter.
// Contents: arbiter state enum, one-hot rotate, one-hot to binary index.
// Helpers work on a 16-bit container (the largest supported N); callers cast in and out.
package rr_arb_pkg;

    localparam int MAX_N = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Rotate the low n bits of v left by one position; bit n-1 wraps to bit 0.
    // Bits at or above n are ignored and return as zero.
    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

    // Binary index of a one-hot vector; 0 for an all-zero input.
    function automatic logic [3:0] onehot2bin(input logic [MAX_N-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                r = r | 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot circulating priority pointer, the ring-counter token used by the arbiter.
// Ports: clk/rst (sync, active-high), adv strobe, owner one-hot; ptr is the registered token.
// On adv the token is placed one position above the owner (circularly); otherwise it holds.
module ring_ptr
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic [N-1:0] owner,
    output logic [N-1:0] ptr
);

    logic [MAX_N-1:0] owner_ext;

    assign owner_ext = MAX_N'(owner);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= N'(1);
        end else if (adv) begin
            ptr <= N'(rotl1(owner_ext, N));
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: N requesters share one resource, priority from a rotating one-hot ring.
// Ports: clk/rst (sync, active-high), req[N]; registered gnt (one-hot), gnt_id, gnt_valid, ptr.
// Grant latency is one cycle; an owner keeps the grant while requesting, up to MAX_HOLD cycles.
module ring_rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic [N-1:0]    ptr
);

    // Hold counter is wide enough to reach MAX_HOLD; unlimited mode still keeps one bit.
    localparam int HC_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_SAT = '1;

    arb_state_t       state;
    logic [HC_W-1:0]  hold_cnt;

    logic [MAX_N-1:0] ptr_ext;
    int               ptr_idx;
    int               base_idx;
    int               sel_idx;
    logic             sel_found;
    logic             owner_req;
    logic             hold_ok;
    logic             rel;

    assign ptr_ext   = MAX_N'(ptr);
    assign ptr_idx   = int'(onehot2bin(ptr_ext));
    assign owner_req = req[gnt_id];
    assign hold_ok   = (MAX_HOLD == 0) || (hold_cnt < HOLD_LIM);
    assign rel       = (state == GRANT) && !(owner_req && hold_ok);

    // On release the search starts just above the old owner, which is exactly
    // where the pointer is about to land; in IDLE it starts at the pointer.
    assign base_idx = (state == GRANT) ? ((int'(gnt_id) + 1) % N) : ptr_idx;

    // Circular first-set search: base, base+1, ..., wrapping at N-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 0;
        for (int off = 0; off < N; off++) begin
            if (!sel_found && req[(base_idx + off) % N]) begin
                sel_found = 1'b1;
                sel_idx   = (base_idx + off) % N;
            end
        end
    end

    ring_ptr #(
        .N (N)
    ) u_ring_ptr (
        .clk   (clk),
        .rst   (rst),
        .adv   (rel),
        .owner (gnt),
        .ptr   (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        state     <= GRANT;
                        gnt       <= N'(1) << sel_idx;
                        gnt_id    <= ID_W'(sel_idx);
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HC_W'(1);
                    end
                end
                GRANT: begin
                    if (!rel) begin
                        // Saturate so unlimited mode never wraps back to a small count.
                        if (hold_cnt != HOLD_SAT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (sel_found) begin
                        // Hand over with no idle gap; may re-grant the old owner.
                        gnt       <= N'(1) << sel_idx;
                        gnt_id    <= ID_W'(sel_idx);
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HC_W'(1);
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter with N=4, MAX_HOLD=4.
// Each step drives rst/req before an edge and queues the expected post-edge outputs;
// after the edge the entry is popped and compared, along with the grant/pointer invariants.
module tb_ring_rr_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int ID_W     = $clog2(N);

    typedef struct {
        string      tag;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ptr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic [N-1:0]    ptr;

    exp_t exp_q[$];
    int   total;
    int   bad;

    ring_rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .ptr       (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] id_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [3:0] ep);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        exp_q.push_back('{tag: tag, req: rq, gnt: eg, ptr: ep});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".gnt"},       32'(gnt),       32'(e.gnt));
        chk({e.tag, ".gnt_id"},    32'(gnt_id),    32'(id_of(e.gnt)));
        chk({e.tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|e.gnt));
        chk({e.tag, ".ptr"},       32'(ptr),       32'(e.ptr));
        chk({e.tag, ".onehot0_gnt"}, 32'($onehot0(gnt)), 32'(1));
        chk({e.tag, ".onehot_ptr"},  32'($onehot(ptr)),  32'(1));
        chk({e.tag, ".gnt_had_req"}, 32'(gnt & ~e.req), 32'(0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;

        // Reset held with all requesting: nothing granted, token at bit 0.
        step("rst0", 1'b1, 4'b1111, 4'b0000, 4'b0001);
        step("rst1", 1'b1, 4'b1111, 4'b0000, 4'b0001);

        // Full load: four-cycle bursts per owner, no gaps, pointer follows owners.
        // The first grant here is the one-cycle-after-reset grant to requester 0.
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 4; c++) begin
                step($sformatf("full_o%0d_c%0d", o, c), 1'b0, 4'b1111,
                     4'(1 << o), 4'(1 << o));
            end
        end
        step("full_wrap", 1'b0, 4'b1111, 4'b0001, 4'b0001);

        // Owner 0 drops with nobody else: idle, token above 0; idle keeps it put.
        step("drop_idle", 1'b0, 4'b0000, 4'b0000, 4'b0010);
        step("idle_hold", 1'b0, 4'b0000, 4'b0000, 4'b0010);

        // Single request from idle, then release.
        step("single_gnt",  1'b0, 4'b0100, 4'b0100, 4'b0010);
        step("single_drop", 1'b0, 4'b0000, 4'b0000, 4'b1000);

        // Sole requester hits the burst limit and is re-granted back-to-back.
        step("sole_c0", 1'b0, 4'b0010, 4'b0010, 4'b1000);
        step("sole_c1", 1'b0, 4'b0010, 4'b0010, 4'b1000);
        step("sole_c2", 1'b0, 4'b0010, 4'b0010, 4'b1000);
        step("sole_c3", 1'b0, 4'b0010, 4'b0010, 4'b1000);
        step("sole_regrant", 1'b0, 4'b0010, 4'b0010, 4'b0100);
        step("sole_cont",    1'b0, 4'b0010, 4'b0010, 4'b0100);

        // Circular search on release.
        step("circ_idle", 1'b0, 4'b0000, 4'b0000, 4'b0100);
        step("circ_own0", 1'b0, 4'b0001, 4'b0001, 4'b0100);
        step("circ_to1",  1'b0, 4'b1010, 4'b0010, 4'b0010);
        step("circ_to3",  1'b0, 4'b1000, 4'b1000, 4'b0100);

        // Reset in the middle of a grant with hold_cnt at 2.
        step("mid_idle",  1'b0, 4'b0000, 4'b0000, 4'b0001);
        step("mid_g1",    1'b0, 4'b0100, 4'b0100, 4'b0001);
        step("mid_g2",    1'b0, 4'b0100, 4'b0100, 4'b0001);
        step("mid_rst",   1'b1, 4'b0100, 4'b0000, 4'b0001);
        step("mid_regnt", 1'b0, 4'b0100, 4'b0100, 4'b0001);
        step("mid_drop",  1'b0, 4'b0000, 4'b0000, 4'b1000);

        total++;
        assert (exp_q.size() == 0)
        else begin
            bad++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is a rotating one-hot ring pointer, the same circulating-token scheme as the team's ring counter.
- Grant is held while the owner keeps requesting, up to a burst limit.
- Sits between requester blocks and a shared datapath resource such as a bus port or counter bank.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.
- ID_W, $clog2(N), width of gnt_id (derived, do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  one-hot grant, registered; all zero when idle.
- gnt_id  output  ID_W  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  equals |gnt.
- ptr  output  N  current one-hot priority pointer (debug/observability).

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. When sampled high at a clk edge, all state returns to reset values at that edge, including mid-grant.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, ptr=one-hot bit 0, state=IDLE, hold_cnt=0.
- States:
  - IDLE: no owner.
  - GRANT: one owner; gnt has exactly one bit set.
- Selection function pick(req, ptr): the first set bit of req found by searching circularly from the ptr position upward (ptr, ptr+1, ..., wrapping at N-1 to 0). Combinational; the result is registered into gnt.
- IDLE -> GRANT: any req bit set at edge k gives gnt=pick(req, ptr) after edge k (latency 1 cycle) and hold_cnt=1. ptr is unchanged.
- GRANT, continue: req[owner]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD) -> keep gnt and increment hold_cnt. The counter saturates; it never wraps.
- GRANT, release: req[owner]=0, or hold_cnt==MAX_HOLD with MAX_HOLD!=0.
  - ptr <= owner rotated left by 1 (bit N-1 wraps to bit 0).
  - If req!=0 at the same edge, gnt <= pick(req, rotated ptr) with hold_cnt=1, staying in GRANT with no idle gap.
  - The old owner is eligible only after every other requester in circular order, so it is re-granted back-to-back if it is the sole requester.
  - Otherwise gnt <= 0 and the state goes to IDLE.
- Req drop: the owner dropping req at edge k removes gnt at edge k+1. A one-cycle overlap of gnt after req falls is legal and expected.
- Pointer movement: ptr moves only on release. It never moves in IDLE, so an idle period does not change fairness.
- Requests outside ownership: requests asserted while another requester owns the grant are queued implicitly, with no latching. A requester that deasserts before selection loses nothing.
- Output consistency: gnt_id and gnt_valid are registered alongside gnt and are always consistent with it in the same cycle.
- Width: hold_cnt width is $clog2(MAX_HOLD+1), minimum 1 bit.
- Invariants for assertions: $onehot0(gnt) always; $onehot(ptr) always; gnt[i] implies req[i] was set in the previous cycle.

Decomposition:
- Package rr_arb_pkg:
  - arb_state_t enum {IDLE, GRANT}.
  - function rotl1 (one-hot rotate).
  - function onehot2bin.
- Sub-module ring_ptr holds the one-hot pointer register. It resets to bit 0 and rotates by one position on an advance strobe, loading owner<<1 circularly. It is reusable and mirrors the ring counter.
- The selection function, FSM and hold counter stay in ring_rr_arbiter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_valid=0, ptr=0001; first grant appears one cycle after rst falls: gnt=0001, gnt_id=0.
2. Single request (N=4, MAX_HOLD=4): from IDLE, req=0100 at edge k -> gnt=0100, gnt_id=2 after edge k. Drop req -> gnt=0000 one edge later, ptr=1000, state IDLE.
3. Full load (MAX_HOLD=4): req=1111 held -> gnt sequence 0001x4, 0010x4, 0100x4, 1000x4, then 0001 again. No zero cycles between owners; ptr advances 0010, 0100, 1000, 0001.
4. Sole requester hits burst limit (MAX_HOLD=4): req=0010 held -> gnt=0010 for 4 cycles, released, re-granted immediately (hold_cnt restarts at 1, gnt stays 0010), ptr=0100.
5. Circular search on release: owner 0 drops req while req=1010 -> next gnt=0010 (search order 1,2,3,0), ptr=0010. When 1 drops, gnt=1000.
6. Reset mid-grant: during gnt=0100 with hold_cnt=2, rst=1 for one edge -> gnt=0000, ptr=0001, hold_cnt=0 at that edge; rst=0 with req=0100 -> gnt=0100 one cycle later.
